// File: rtl/vhdci_link_pkg.sv
// Shared definitions for both ends of the VHDCI mux link: link states,
// default framing words and the sync-word classifier.
package vhdci_link_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACK    = 2'd1,
        LINKED = 2'd2
    } link_state_e;

    localparam logic [7:0] SYNC_WORD_DEF = 8'h01;
    localparam logic [7:0] ACK_WORD_DEF  = 8'h81;

    // A word that could belong to the alignment handshake.
    function automatic logic sync_like(input logic [7:0] w,
                                       input logic [7:0] sync_w,
                                       input logic [7:0] ack_w);
        return (w == sync_w) || (w == ack_w);
    endfunction

endpackage

// File: rtl/vhdci_link_peer_if.sv
// SERDES-side and user-side signals of the far-end link peer.
// master = the peer itself, slave = whatever surrounds it.
interface vhdci_link_peer_if #(
    parameter int LOSS_CNT_W = 8
);
    logic [7:0]            rx_word;
    logic [7:0]            tx_word;
    logic                  bitslip;
    logic [6:0]            tx_data;
    logic [6:0]            rx_data;
    logic                  rx_valid;
    logic                  link_up;
    logic [LOSS_CNT_W-1:0] loss_count;
    logic [1:0]            state_dbg;

    modport master (
        input  rx_word, tx_data,
        output tx_word, bitslip, rx_data, rx_valid, link_up, loss_count, state_dbg
    );

    modport slave (
        output rx_word, tx_data,
        input  tx_word, bitslip, rx_data, rx_valid, link_up, loss_count, state_dbg
    );
endinterface

// File: rtl/vhdci_toggle_mon.sv
// Liveness-bit checker: ignores IDLE_WORD until the first real word, learns
// the expected bit-7 phase from it, then checks that bit 7 alternates.
module vhdci_toggle_mon
    import vhdci_link_pkg::*;
#(
    parameter logic [7:0] IDLE_WORD = ACK_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] word,
    output logic       arm,
    output logic       match,
    output logic       err
);
    logic armed_q;
    logic expect_q;

    assign arm   = armed_q;
    assign match = (word[7] == expect_q);
    assign err   = en & armed_q & ~match;

    // Disarm whenever disabled so every new link starts by learning the phase.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            armed_q  <= 1'b0;
            expect_q <= 1'b0;
        end else if (!armed_q) begin
            if (word != IDLE_WORD) begin
                armed_q  <= 1'b1;
                expect_q <= ~word[7];
            end
        end else if (match) begin
            expect_q <= ~word[7];
        end else begin
            armed_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/vhdci_link_peer.sv
// Far-end framing engine: answers the host's alignment handshake, slips
// its own ISERDES until sync is seen, then frames 7-bit payloads with a
// toggling liveness bit and drops the link when the host's toggle stalls.
module vhdci_link_peer
    import vhdci_link_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD       = SYNC_WORD_DEF,
    parameter logic [7:0] ACK_WORD        = ACK_WORD_DEF,
    parameter int         BITSLIP_HOLDOFF = 3,
    parameter int         ACK_TIMEOUT     = 1024,
    parameter int         LOSS_CNT_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    vhdci_link_peer_if.master bus
);
    localparam int HOLD_W = $clog2(BITSLIP_HOLDOFF + 1);
    localparam int TMR_W  = $clog2(ACK_TIMEOUT);

    link_state_e           state_q, state_nxt;
    logic [HOLD_W-1:0]     holdoff_q, holdoff_nxt;
    logic [TMR_W-1:0]      timer_q, timer_nxt;
    logic                  toggle_q, toggle_nxt;
    logic [7:0]            tx_word_q, tx_word_nxt;
    logic                  bitslip_q, bitslip_nxt;
    logic [6:0]            rx_data_q, rx_data_nxt;
    logic                  rx_valid_q, rx_valid_nxt;
    logic                  link_up_q;
    logic [LOSS_CNT_W-1:0] loss_q, loss_nxt;

    logic mon_arm, mon_match, mon_err;

    vhdci_toggle_mon #(.IDLE_WORD(ACK_WORD)) u_mon (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (state_q == LINKED),
        .word  (bus.rx_word),
        .arm   (mon_arm),
        .match (mon_match),
        .err   (mon_err)
    );

    // Next-state and next-output decode; every output is a flop fed from here.
    always_comb begin
        state_nxt    = state_q;
        holdoff_nxt  = holdoff_q;
        timer_nxt    = timer_q;
        toggle_nxt   = toggle_q;
        tx_word_nxt  = tx_word_q;
        bitslip_nxt  = 1'b0;
        rx_data_nxt  = rx_data_q;
        rx_valid_nxt = 1'b0;
        loss_nxt     = loss_q;
        case (state_q)
            HUNT: begin
                tx_word_nxt = SYNC_WORD;
                if (holdoff_q != '0) begin
                    holdoff_nxt = holdoff_q - 1'b1;
                end else if (sync_like(bus.rx_word, SYNC_WORD, ACK_WORD)) begin
                    state_nxt   = ACK;
                    timer_nxt   = '0;
                    tx_word_nxt = ACK_WORD;
                end else begin
                    bitslip_nxt = 1'b1;
                    holdoff_nxt = HOLD_W'(BITSLIP_HOLDOFF);
                end
            end
            ACK: begin
                tx_word_nxt = ACK_WORD;
                if (bus.rx_word == ACK_WORD) begin
                    // toggle tracks bit 7 of the word currently on tx_word
                    state_nxt   = LINKED;
                    toggle_nxt  = 1'b0;
                    tx_word_nxt = {1'b0, bus.tx_data};
                end else if (bus.rx_word != SYNC_WORD ||
                             timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt   = HUNT;
                    holdoff_nxt = '0;
                    tx_word_nxt = SYNC_WORD;
                end else begin
                    timer_nxt = timer_q + 1'b1;
                end
            end
            LINKED: begin
                toggle_nxt  = ~toggle_q;
                tx_word_nxt = {~toggle_q, bus.tx_data};
                if (mon_err) begin
                    state_nxt   = HUNT;
                    holdoff_nxt = '0;
                    toggle_nxt  = 1'b0;
                    tx_word_nxt = SYNC_WORD;
                    if (loss_q != '1) loss_nxt = loss_q + 1'b1;
                end else if (mon_arm && mon_match) begin
                    rx_valid_nxt = 1'b1;
                    rx_data_nxt  = bus.rx_word[6:0];
                end
            end
            default: begin
                state_nxt   = HUNT;
                tx_word_nxt = SYNC_WORD;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= HUNT;
            holdoff_q  <= '0;
            timer_q    <= '0;
            toggle_q   <= 1'b0;
            tx_word_q  <= SYNC_WORD;
            bitslip_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            link_up_q  <= 1'b0;
            loss_q     <= '0;
        end else begin
            state_q    <= state_nxt;
            holdoff_q  <= holdoff_nxt;
            timer_q    <= timer_nxt;
            toggle_q   <= toggle_nxt;
            tx_word_q  <= tx_word_nxt;
            bitslip_q  <= bitslip_nxt;
            rx_data_q  <= rx_data_nxt;
            rx_valid_q <= rx_valid_nxt;
            link_up_q  <= (state_nxt == LINKED);
            loss_q     <= loss_nxt;
        end
    end

    assign bus.tx_word    = tx_word_q;
    assign bus.bitslip    = bitslip_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.link_up    = link_up_q;
    assign bus.loss_count = loss_q;
    assign bus.state_dbg  = state_q;

endmodule
